// File: rtl/sklansky_adder_16.sv
// sklansky_adder_16 -- registered 16-bit unsigned adder with a 4-level
// Sklansky parallel-prefix carry network and no carry-in.
//
// Ports:
//   clk  in   1  rising-edge clock
//   rst  in   1  asynchronous active-high reset (clears SUM/CO)
//   A    in  16  unsigned addend
//   B    in  16  unsigned addend
//   SUM  out 16  registered (A+B) mod 2^16, one cycle after A/B are sampled
//   CO   out  1  registered carry-out (bit 16 of A+B)

// 2-input AND primitive.
module an2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

// 2-input OR primitive.
module or2 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a | b;
endmodule

// Full adder; callers may ignore co.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module sklansky_adder_16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] SUM,
  output logic        CO
);

  // g_lvl[k][i] / p_lvl[k][i]: group generate/propagate from bit i down to
  // the bottom of its 2^k-aligned block. Level 0 is the per-bit signals.
  logic [15:0] g_lvl [0:3];
  logic [15:0] p_lvl [0:3];
  logic [15:0] g_pre;          // g_pre[i] = group generate over bits i..0
  logic [16:0] c;              // c[i] = carry into bit i
  logic [15:0] sum_d;
  logic [15:1] unused_fa_co;
  logic        unused_p;

  genvar i, l;

  for (i = 0; i < 16; i++) begin : g_bit
    an2 u_g (.a(A[i]), .b(B[i]), .y(g_lvl[0][i]));
    or2 u_p (.a(A[i]), .b(B[i]), .y(p_lvl[0][i]));
  end

  // Levels 1..3: a bit in the upper half of its 2^l block absorbs the prefix
  // ending at the top of the lower half; other bits pass through unchanged.
  for (l = 1; l < 4; l++) begin : g_level
    for (i = 0; i < 16; i++) begin : g_node
      localparam int S = 1 << (l - 1);
      localparam int J = (i / S) * S - 1;
      if (((i / S) % 2) == 1) begin : g_op
        logic pg;
        an2 u_pg (.a(p_lvl[l-1][i]), .b(g_lvl[l-1][J]), .y(pg));
        or2 u_g  (.a(g_lvl[l-1][i]), .b(pg), .y(g_lvl[l][i]));
        an2 u_p  (.a(p_lvl[l-1][i]), .b(p_lvl[l-1][J]), .y(p_lvl[l][i]));
      end else begin : g_pass
        assign g_lvl[l][i] = g_lvl[l-1][i];
        assign p_lvl[l][i] = p_lvl[l-1][i];
      end
    end
  end

  // Level 4: upper byte absorbs the bit-7 group generate; generate only.
  for (i = 0; i < 16; i++) begin : g_l4
    if (i >= 8) begin : g_op
      logic pg;
      an2 u_pg (.a(p_lvl[3][i]), .b(g_lvl[3][7]), .y(pg));
      or2 u_g  (.a(g_lvl[3][i]), .b(pg), .y(g_pre[i]));
    end else begin : g_pass
      assign g_pre[i] = g_lvl[3][i];
    end
  end

  // Lower-byte group propagates are not needed once level 4 drops P.
  assign unused_p = ^p_lvl[3][7:0];

  assign c[0]    = 1'b0;
  assign c[16:1] = g_pre;

  assign sum_d[0] = A[0] ^ B[0];

  for (i = 1; i < 16; i++) begin : g_sum
    fa u_fa (.a(A[i]), .b(B[i]), .ci(c[i]), .s(sum_d[i]), .co(unused_fa_co[i]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SUM <= '0;
      CO  <= 1'b0;
    end else begin
      SUM <= sum_d;
      CO  <= c[16];
    end
  end

endmodule

// File: tb/tb_sklansky_adder_16.sv
// tb_sklansky_adder_16 -- self-checking bench for sklansky_adder_16:
// directed vector table, reset corner cases, and random back-to-back
// operands compared against plain 17-bit addition.
module tb_sklansky_adder_16;

  logic        clk;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] SUM;
  logic        CO;

  int unsigned n_checks;
  int unsigned n_fail;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        co;
  } vec_t;

  vec_t vecs [0:9];

  sklansky_adder_16 dut (
    .clk(clk),
    .rst(rst),
    .A  (A),
    .B  (B),
    .SUM(SUM),
    .CO (CO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] exp_sum,
                       input logic exp_co);
    n_checks++;
    if (SUM !== exp_sum || CO !== exp_co) begin
      n_fail++;
      $display("FAIL %s: got SUM=%h CO=%b, expected SUM=%h CO=%b",
               name, SUM, CO, exp_sum, exp_co);
    end
  endtask

  // Drive operands away from the active edge, then sample #1 after it.
  task automatic step(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    A = a;
    B = b;
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain unsigned 17-bit addition.
  function automatic logic [16:0] ref_add(input logic [15:0] a,
                                          input logic [15:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  initial begin
    logic [16:0] exp;
    logic [15:0] ra, rb;

    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    vecs[1] = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h8000, 16'h7FFF, 1'b1};
    vecs[3] = '{16'hFFFF, 16'hAAAA, 16'hAAA9, 1'b1};
    vecs[4] = '{16'hFFFF, 16'h5555, 16'h5554, 1'b1};
    vecs[5] = '{16'h001F, 16'h5555, 16'h5574, 1'b0};
    vecs[6] = '{16'h001F, 16'h0010, 16'h002F, 1'b0};
    vecs[7] = '{16'h001F, 16'hE9E0, 16'hE9FF, 1'b0};
    vecs[8] = '{16'h3E5E, 16'hE9E0, 16'h283E, 1'b1};
    vecs[9] = '{16'h3E5E, 16'hFFFF, 16'h3E5D, 1'b1};

    rst = 1'b0;
    A   = 16'h0001;
    B   = 16'h0001;

    // Load a non-zero result so the async clear is observable.
    @(posedge clk);
    #1;
    check("preload", 16'h0002, 1'b0);

    // Reset asserted between edges clears outputs immediately.
    @(negedge clk);
    A   = 16'hFFFF;
    B   = 16'hFFFF;
    #1;
    rst = 1'b1;
    #1;
    check("async_reset", 16'h0000, 1'b0);
    @(posedge clk);
    #1;
    check("reset_held", 16'h0000, 1'b0);

    // First edge after release captures FFFF+FFFF.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_release", 16'hFFFE, 1'b1);

    for (int unsigned k = 0; k < 10; k++) begin
      step(vecs[k].a, vecs[k].b);
      check($sformatf("vec%0d", k), vecs[k].sum, vecs[k].co);
    end

    // Mid-stream reset discards the in-flight pair.
    @(negedge clk);
    A   = 16'h1234;
    B   = 16'h4321;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midstream_reset", 16'h0000, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    A   = 16'h8001;
    B   = 16'h8001;
    @(posedge clk);
    #1;
    check("after_midstream", 16'h0002, 1'b1);

    // Random back-to-back: one new pair per cycle, result due next edge.
    for (int unsigned k = 0; k < 10000; k++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      exp = ref_add(ra, rb);
      step(ra, rb);
      check($sformatf("rand%0d_%h_%h", k, ra, rb), exp[15:0], exp[16]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sklansky_adder_16.md
SKLANSKY_ADDER_16 -- requirements
Module: sklansky_adder_16

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 16 bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Port `clk`: input, 1 bit, rising-edge clock for all state.
REQ-004 Port `rst`: input, 1 bit, asynchronous active-high reset.
REQ-005 Port `A`: input, 16 bits, unsigned addend, bit 0 = LSB.
REQ-006 Port `B`: input, 16 bits, unsigned addend, bit 0 = LSB.
REQ-007 Port `SUM`: output, 16 bits, registered (A+B) mod 2^16.
REQ-008 Port `CO`: output, 1 bit, registered carry-out, i.e. bit 16 of A+B.

Function
REQ-009 The block SHALL have no carry-in; `{CO,SUM}` SHALL equal the full 17-bit unsigned sum A+B.
REQ-010 Per-bit signals SHALL be generate G[i]=A[i]&B[i] and propagate P[i]=A[i]|B[i], built from 2-input AND (AN2) and 2-input OR (OR2) primitive cells.
REQ-011 The prefix operator SHALL be (Pl,Gl)o(Pr,Gr) = (Pl&Pr, Gl|(Pl&Gr)), with l the more-significant group and r the less-significant group.
REQ-012 The carry tree SHALL be a 4-level Sklansky (divide-and-conquer) prefix network:
- level 1 combines 2-bit spans;
- level 2 produces 4-bit group prefixes;
- level 3 produces 8-bit group prefixes;
- level 4 combines the bit-7 group generate with the upper 8 bits.
REQ-013 Level 4 SHALL compute group generate only; no group propagate.
REQ-014 Carry into bit i (c[i]) SHALL be the group generate over bits i-1..0, with c[0]=0; CO SHALL be the group generate over bits 15..0.
REQ-015 Sum bit 0 SHALL be A[0]^B[0].
REQ-016 Sum bit i for i=1..15 SHALL be the sum output of a full-adder (FA) cell with inputs A[i], B[i] and CI=c[i]; the FA carry-out SHALL be left unused.
REQ-017 Latency SHALL be exactly one clock: A and B sampled at rising edge n SHALL appear on SUM/CO after edge n.
REQ-018 A new operand pair SHALL be accepted every cycle; there is no handshake or stall.
REQ-019 Overflow SHALL wrap SUM modulo 2^16 and set CO=1; no saturation.

Reset
REQ-020 While `rst`=1, SUM SHALL be 16'h0000 and CO SHALL be 0, immediately and independent of `clk`.
REQ-021 On reset deassertion, the first registered result SHALL appear after the first rising edge with `rst`=0.
REQ-022 Reset asserted mid-stream SHALL discard the in-flight result; there is no other internal state.

Verification
REQ-023 The bench SHALL cover these directed scenarios (each result checked one cycle after the operands are applied):
- Reset: assert rst with A=FFFF, B=FFFF -> SUM=0000, CO=0 with no clock edge required; release rst, one edge -> SUM=FFFE, CO=1.
- Full carry ripple: A=FFFF, B=0001 -> SUM=0000, CO=1; then A=FFFF, B=0000 -> SUM=FFFF, CO=0.
- MSB and alternating patterns: FFFF+8000 -> 7FFF/1; FFFF+AAAA -> AAA9/1; FFFF+5555 -> 5554/1.
- Mid-range, no carry-out: 001F+5555 -> 5574/0; 001F+0010 -> 002F/0; 001F+E9E0 -> E9FF/0.
- Upper-half carry through level 4: 3E5E+E9E0 -> 283E/1; 3E5E+FFFF -> 3E5D/1.
- Random back-to-back: at least 10^4 random A/B pairs applied every cycle -> {CO,SUM} equals A+B with exactly 1-cycle latency.
